// File: rtl/ww_svm_sample_sequencer_if.sv
// Stream bundle between the white-wine SVM sample sequencer and its neighbours.
//   feat_*  : serial feature beats (valid/ready, feat_sof marks feature index 0)
//   res_*   : captured classifier result (valid/ready)
// Modports:
//   master : the side that produces features and consumes results
//   slave  : the sequencer side
interface ww_svm_sample_sequencer_if #(
    parameter int unsigned WIDTH_A  = 4,
    parameter int unsigned OUTWIDTH = 13
);
    logic                feat_valid;
    logic                feat_sof;
    logic [WIDTH_A-1:0]  feat_data;
    logic                feat_ready;
    logic                res_valid;
    logic [OUTWIDTH-1:0] res_data;
    logic                res_ready;

    modport master (
        output feat_valid, feat_sof, feat_data,
        input  feat_ready,
        input  res_valid, res_data,
        output res_ready
    );

    modport slave (
        input  feat_valid, feat_sof, feat_data,
        output feat_ready,
        output res_valid, res_data,
        input  res_ready
    );
endinterface

// File: rtl/ww_svm_sample_sequencer.sv
// Sequencer in front of the combinational white-wine SVM classifier.
// Collects NUM_A features of WIDTH_A bits serially, drives them as one flat vector
// into the classifier, waits SETTLE_CYCLES for slow logic to propagate, captures the
// result and offers it on a valid/ready port. One sample in flight at a time.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   bus         : feature stream in / result stream out (slave modport)
//   clf_inp     : classifier input; feature i at [(i+1)*WIDTH_A-1 : i*WIDTH_A]
//   clf_out     : classifier output
//   busy        : high while settling or holding a result
//   err_sof     : one-cycle pulse when feat_sof restarts a partial sample
//   sample_cnt  : results delivered since reset, wrapping
module ww_svm_sample_sequencer #(
    parameter int unsigned WIDTH_A       = 4,
    parameter int unsigned NUM_A         = 11,
    parameter int unsigned OUTWIDTH      = 13,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    ww_svm_sample_sequencer_if.slave   bus,
    output logic [NUM_A*WIDTH_A-1:0]   clf_inp,
    input  logic [OUTWIDTH-1:0]        clf_out,
    output logic                       busy,
    output logic                       err_sof,
    output logic [CNT_W-1:0]           sample_cnt
);

    localparam int unsigned IDX_W = (NUM_A > 1) ? $clog2(NUM_A) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_A - 1);
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    localparam logic [1:0] ST_COLLECT = 2'd0;
    localparam logic [1:0] ST_SETTLE  = 2'd1;
    localparam logic [1:0] ST_HOLD    = 2'd2;

    logic [1:0]          state;
    logic [IDX_W-1:0]    idx;
    logic [7:0]          settle_cnt;
    logic                res_valid_r;
    logic [OUTWIDTH-1:0] res_data_r;
    logic                accept;
    logic                resync;

    assign bus.feat_ready = (state == ST_COLLECT) && !rst;
    assign bus.res_valid  = res_valid_r;
    assign bus.res_data   = res_data_r;
    assign busy           = (state != ST_COLLECT);

    assign accept = bus.feat_valid && bus.feat_ready;
    // A start-of-sample marker in the middle of a sample restarts collection at slot 0.
    assign resync = bus.feat_sof && (idx != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_COLLECT;
            idx         <= '0;
            settle_cnt  <= '0;
            clf_inp     <= '0;
            res_valid_r <= 1'b0;
            res_data_r  <= '0;
            err_sof     <= 1'b0;
            sample_cnt  <= '0;
        end else begin
            err_sof <= 1'b0;
            case (state)
                ST_COLLECT: begin
                    if (accept) begin
                        if (resync) begin
                            // Slots 1.. keep stale data until the new sample overwrites them.
                            clf_inp[WIDTH_A-1:0] <= bus.feat_data;
                            idx                  <= IDX_W'(1);
                            err_sof              <= 1'b1;
                        end else begin
                            for (int i = 0; i < int'(NUM_A); i++) begin
                                if (int'(idx) == i) begin
                                    clf_inp[i*WIDTH_A +: WIDTH_A] <= bus.feat_data;
                                end
                            end
                            if (idx == LAST_IDX) begin
                                idx        <= '0;
                                settle_cnt <= '0;
                                state      <= ST_SETTLE;
                            end else begin
                                idx <= idx + IDX_W'(1);
                            end
                        end
                    end
                end
                ST_SETTLE: begin
                    settle_cnt <= settle_cnt + 8'd1;
                    if (settle_cnt == SETTLE_LAST) begin
                        res_data_r  <= clf_out;
                        res_valid_r <= 1'b1;
                        state       <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (res_valid_r && bus.res_ready) begin
                        res_valid_r <= 1'b0;
                        sample_cnt  <= sample_cnt + CNT_W'(1);
                        state       <= ST_COLLECT;
                    end
                end
                default: state <= ST_COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_ww_svm_sample_sequencer.sv
// Bench for ww_svm_sample_sequencer. Instance A uses the default build (settle 4,
// 16-bit counter); instance B uses settle 1 and a 2-bit counter with res_ready tied
// high. The classifier is stubbed as the sum of the eleven features.
module tb_ww_svm_sample_sequencer;

    localparam int WA = 4;
    localparam int NA = 11;
    localparam int OW = 13;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ww_svm_sample_sequencer_if #(.WIDTH_A(WA), .OUTWIDTH(OW)) bus_a ();
    ww_svm_sample_sequencer_if #(.WIDTH_A(WA), .OUTWIDTH(OW)) bus_b ();

    logic [NA*WA-1:0] clf_inp_a, clf_inp_b;
    logic [OW-1:0]    clf_out_a, clf_out_b;
    logic             busy_a, busy_b, err_a, err_b;
    logic [15:0]      cnt_a;
    logic [1:0]       cnt_b;

    ww_svm_sample_sequencer #(.SETTLE_CYCLES(4), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a), .clf_inp(clf_inp_a), .clf_out(clf_out_a),
        .busy(busy_a), .err_sof(err_a), .sample_cnt(cnt_a)
    );

    ww_svm_sample_sequencer #(.SETTLE_CYCLES(1), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b), .clf_inp(clf_inp_b), .clf_out(clf_out_b),
        .busy(busy_b), .err_sof(err_b), .sample_cnt(cnt_b)
    );

    function automatic logic [OW-1:0] stub_sum(input logic [NA*WA-1:0] v);
        logic [OW-1:0] s = '0;
        for (int i = 0; i < NA; i++) s = s + OW'(v[i*WA +: WA]);
        return s;
    endfunction

    always_comb clf_out_a = stub_sum(clf_inp_a);
    always_comb clf_out_b = stub_sum(clf_inp_b);

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model for instance A: slot array, write position, delivered count.
    logic [WA-1:0] m_slot[NA];
    int            m_idx;
    int            m_cnt;
    bit            m_err;

    function automatic logic [NA*WA-1:0] m_vec();
        logic [NA*WA-1:0] v;
        for (int i = 0; i < NA; i++) v[i*WA +: WA] = m_slot[i];
        return v;
    endfunction

    function automatic int m_sum();
        int s = 0;
        for (int i = 0; i < NA; i++) s += int'(m_slot[i]);
        return s;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NA; i++) m_slot[i] = '0;
        m_idx = 0;
        m_cnt = 0;
        m_err = 0;
    endtask

    task automatic model_beat(input logic [WA-1:0] d, input bit sof);
        if (sof && m_idx != 0) begin
            m_slot[0] = d;
            m_idx     = 1;
            m_err     = 1;
        end else begin
            m_err        = 0;
            m_slot[m_idx] = d;
            m_idx        = (m_idx == NA - 1) ? 0 : m_idx + 1;
        end
    endtask

    // Present one beat from the next falling edge and hold it until accepted.
    task automatic send_beat(input bit sel, input logic [WA-1:0] d, input bit sof,
                             input int gap);
        bit ok = 0;
        repeat (gap) @(negedge clk);
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (sel) begin
                bus_b.feat_valid = 1'b1; bus_b.feat_sof = sof; bus_b.feat_data = d;
            end else begin
                bus_a.feat_valid = 1'b1; bus_a.feat_sof = sof; bus_a.feat_data = d;
            end
            #1;
            if (sel ? bus_b.feat_ready : bus_a.feat_ready) begin
                @(posedge clk);
                ok = 1;
                break;
            end
        end
        #1;
        if (sel) bus_b.feat_valid = 1'b0;
        else     bus_a.feat_valid = 1'b0;
        check("beat_accepted", 64'(ok), 64'd1);
    endtask

    task automatic a_beat(input logic [WA-1:0] d, input bit sof, input int gap);
        model_beat(d, sof);
        send_beat(1'b0, d, sof, gap);
    endtask

    // Count rising edges until res_valid is seen (sampled 1 ns after each edge).
    task automatic wait_result(input bit sel, output int cyc);
        bit seen = 0;
        cyc = 0;
        while (!seen && cyc < 50) begin
            @(posedge clk);
            #1;
            cyc++;
            seen = sel ? bus_b.res_valid : bus_a.res_valid;
        end
        check("result_timeout", 64'(seen), 64'd1);
    endtask

    task automatic release_a();
        @(negedge clk);
        bus_a.res_ready = 1'b1;
        @(posedge clk);
        #1;
        m_cnt++;
        check("rel_res_valid", 64'(bus_a.res_valid), 64'd0);
        check("rel_feat_ready", 64'(bus_a.feat_ready), 64'd1);
        check("rel_sample_cnt", 64'(cnt_a), 64'(16'(m_cnt)));
        @(negedge clk);
        bus_a.res_ready = 1'b0;
    endtask

    task automatic check_result_a(input string tag);
        int cyc;
        wait_result(1'b0, cyc);
        check({tag, "_latency"}, 64'(cyc), 64'd4);
        check({tag, "_res_data"}, 64'(bus_a.res_data), 64'(m_sum()));
        check({tag, "_clf_inp"}, 64'(clf_inp_a), 64'(m_vec()));
        check({tag, "_busy"}, 64'(busy_a), 64'd1);
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, "_feat_ready"}, 64'(bus_a.feat_ready), 64'd0);
        check({tag, "_res_valid"}, 64'(bus_a.res_valid), 64'd0);
        check({tag, "_res_data"}, 64'(bus_a.res_data), 64'd0);
        check({tag, "_clf_inp"}, 64'(clf_inp_a), 64'd0);
        check({tag, "_busy"}, 64'(busy_a), 64'd0);
        check({tag, "_err_sof"}, 64'(err_a), 64'd0);
        check({tag, "_cnt"}, 64'(cnt_a), 64'd0);
    endtask

    typedef struct {
        logic [NA*WA-1:0] feat;
        bit               sof;
        logic [OW-1:0]    exp;
    } vec_t;

    vec_t tbl[4];

    initial begin
        logic [NA*WA-1:0] rv;
        int               cyc;
        time              t_last[4];

        tbl[0] = '{feat: 44'hBA987654321, sof: 1'b1, exp: 13'd66};
        tbl[1] = '{feat: 44'hFFFFFFFFFFF, sof: 1'b1, exp: 13'd165};
        tbl[2] = '{feat: 44'h00000000000, sof: 1'b0, exp: 13'd0};
        tbl[3] = '{feat: 44'h30303030303, sof: 1'b0, exp: 13'd18};

        bus_a.feat_valid = 0; bus_a.feat_sof = 0; bus_a.feat_data = '0; bus_a.res_ready = 0;
        bus_b.feat_valid = 0; bus_b.feat_sof = 0; bus_b.feat_data = '0; bus_b.res_ready = 1;
        model_reset();

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_a("reset");
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_release_ready", 64'(bus_a.feat_ready), 64'd1);

        // Table-driven samples; the first also exercises result back-pressure.
        for (int v = 0; v < 4; v++) begin
            for (int i = 0; i < NA; i++)
                a_beat(tbl[v].feat[i*WA +: WA], (i == 0) && tbl[v].sof, 0);
            check_result_a($sformatf("tbl%0d", v));
            check($sformatf("tbl%0d_expected", v), 64'(bus_a.res_data), 64'(tbl[v].exp));
            check($sformatf("tbl%0d_vector", v), 64'(clf_inp_a), 64'(tbl[v].feat));
            if (v == 0) begin
                @(negedge clk);
                bus_a.feat_valid = 1'b1; bus_a.feat_sof = 1'b1; bus_a.feat_data = 4'd5;
                repeat (20) begin
                    @(posedge clk);
                    #1;
                    check("stall_res_data", 64'(bus_a.res_data), 64'(tbl[0].exp));
                    check("stall_res_valid", 64'(bus_a.res_valid), 64'd1);
                    check("stall_feat_ready", 64'(bus_a.feat_ready), 64'd0);
                    check("stall_clf_inp", 64'(clf_inp_a), 64'(tbl[0].feat));
                end
                bus_a.feat_valid = 1'b0;
            end
            release_a();
        end

        // Resynchronisation: 5 beats, then a start-of-sample with data 9.
        for (int i = 0; i < 5; i++) a_beat(WA'(i + 1), i == 0, 0);
        check("pre_resync_err", 64'(err_a), 64'd0);
        a_beat(4'd9, 1'b1, 0);
        check("resync_err_pulse", 64'(err_a), 64'(m_err));
        check("resync_stale_inp", 64'(clf_inp_a), 64'(m_vec()));
        @(posedge clk);
        #1;
        check("resync_err_clear", 64'(err_a), 64'd0);
        for (int i = 1; i < NA; i++) a_beat(WA'(i + 4), 1'b0, 0);
        check("resync_slot0", 64'(clf_inp_a[3:0]), 64'd9);
        check_result_a("resync");
        release_a();

        // Randomised samples with idle gaps and random result back-pressure.
        for (int s = 0; s < 15; s++) begin
            rv = {12'($urandom), $urandom};
            for (int i = 0; i < NA; i++)
                a_beat(rv[i*WA +: WA], (i == 0) && ($urandom_range(0, 1) == 1),
                       int'($urandom_range(0, 2)));
            check_result_a($sformatf("rand%0d", s));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            release_a();
        end

        // Reset in the middle of SETTLE.
        for (int i = 0; i < NA; i++) a_beat(tbl[1].feat[i*WA +: WA], i == 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        check_reset_a("rst_settle");
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_settle_ready", 64'(bus_a.feat_ready), 64'd1);
        repeat (6) @(posedge clk);
        #1;
        check("rst_settle_no_result", 64'(bus_a.res_valid), 64'd0);

        // Reset while HOLDing an unconsumed result.
        for (int i = 0; i < NA; i++) a_beat(tbl[0].feat[i*WA +: WA], i == 0, 0);
        check_result_a("pre_rst_hold");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        check_reset_a("rst_hold");
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_hold_ready", 64'(bus_a.feat_ready), 64'd1);

        // Normal operation resumes after reset.
        for (int i = 0; i < NA; i++) a_beat(tbl[3].feat[i*WA +: WA], 1'b0, 0);
        check_result_a("post_rst");
        release_a();

        // Instance B: settle 1, back-to-back samples, 2-bit counter wraps after 4.
        for (int s = 0; s < 4; s++) begin
            for (int i = 0; i < NA; i++) send_beat(1'b1, WA'(s + 1), i == 0, 0);
            t_last[s] = $time;
            wait_result(1'b1, cyc);
            check($sformatf("b%0d_latency", s), 64'(cyc), 64'd1);
            check($sformatf("b%0d_res_data", s), 64'(bus_b.res_data), 64'(11 * (s + 1)));
            @(posedge clk);
            #1;
            check($sformatf("b%0d_res_valid_drop", s), 64'(bus_b.res_valid), 64'd0);
            check($sformatf("b%0d_cnt", s), 64'(cnt_b), 64'((s + 1) % 4));
            if (s > 0)
                check($sformatf("b%0d_throughput", s), 64'(t_last[s] - t_last[s-1]), 64'd130);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ww_svm_sample_sequencer.md
Name:
ww_svm_sample_sequencer

Overview:
- Sequencer in front of the combinational white-wine SVM regression classifier `top`, which has a 44-bit feature input and a 13-bit output.
- Accepts the 11 four-bit features of one sample serially over a valid/ready stream and assembles them into the flat classifier input vector.
- Holds that vector stable for a programmable settle window, sized for slow printed-logic propagation.
- Captures the classifier output and presents it on a valid/ready result port, one sample in flight at a time.

Parameters:
- WIDTH_A, 4, width of one feature.
- NUM_A, 11, features per sample.
- OUTWIDTH, 13, classifier output width.
- SETTLE_CYCLES, 4, clock cycles the assembled vector is held before capture; legal range 1..255.
- CNT_W, 16, width of the delivered-sample counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- feat_valid  in  1  feature beat valid.
- feat_sof  in  1  start of sample; qualifies the current beat as feature index 0.
- feat_data  in  WIDTH_A  feature value.
- feat_ready  out  1  beat accepted on a clk edge when feat_valid&&feat_ready.
- clf_inp  out  NUM_A*WIDTH_A  drives classifier inp; feature i occupies bits [(i+1)*WIDTH_A-1 : i*WIDTH_A].
- clf_out  in  OUTWIDTH  classifier out.
- res_valid  out  1  result available.
- res_data  out  OUTWIDTH  captured classifier output.
- res_ready  in  1  result consumed on an edge when res_valid&&res_ready.
- busy  out  1  high in SETTLE or HOLD.
- err_sof  out  1  one-cycle pulse on a resynchronisation event.
- sample_cnt  out  CNT_W  results delivered since reset; wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst high at an edge):
  - state=COLLECT, idx=0, clf_inp=0, res_data=0, res_valid=0, err_sof=0, sample_cnt=0, settle counter=0.
  - feat_ready=0 in any cycle where rst is high.
  - Reset in any state aborts the sample in progress; no result is emitted.
- feat_ready = (state==COLLECT)&&!rst, combinational.
- busy = (state!=COLLECT).
- COLLECT, on an accepted beat:
  - Normal case: write feat_data to slot idx, idx++.
  - If feat_sof=1 and idx!=0: discard the partial sample, write feat_data to slot 0, set idx=1, pulse err_sof for the following cycle. Previously written slots keep stale values until overwritten.
  - If feat_sof=0 and idx==0: accepted as slot 0; no error.
  - If the accepted beat fills slot NUM_A-1 (and is not a resync): idx=0, settle counter=0, go to SETTLE.
- SETTLE:
  - feat_ready=0; clf_inp stable.
  - Counter increments each cycle.
  - On the edge where the counter equals SETTLE_CYCLES-1: res_data<=clf_out, res_valid<=1, go to HOLD.
  - Latency: if the last feature is accepted at edge T, res_valid is high after edge T+SETTLE_CYCLES, and res_data holds clf_out as sampled at that edge.
- HOLD:
  - res_valid=1; res_data and clf_inp stable.
  - On res_valid&&res_ready: res_valid<=0, sample_cnt++ (wrapping), go to COLLECT.
  - feat_ready rises the cycle after the handshake; features are never accepted in the same cycle as the result handshake.
- res_ready asserted while res_valid=0 has no effect.
- feat_valid outside COLLECT is ignored; the beat stays pending at the source.
- clf_inp retains the last completed vector until slot writes of the next sample overwrite it.
- Classifier output is never sampled during COLLECT.

Test Plan:
- Reset, then stream features 1..11 (feat_sof on the first), res_ready=1, classifier model stubbed as out = sum of features = 66:
  - clf_inp = {4'd11,...,4'd2,4'd1};
  - res_valid rises exactly 4 cycles after the 11th accept, res_data=66;
  - sample_cnt=1.
- res_ready held 0 for 20 cycles after res_valid:
  - res_data stays stable, feat_ready stays 0, feat_valid beats are not accepted.
  - Release res_ready: res_valid drops and feat_ready=1 on the next cycle.
- Send 5 beats, then a beat with feat_sof=1 and data=9:
  - err_sof pulses once, idx restarts at 1;
  - after 10 more beats the result corresponds to the new sample with slot 0=9.
- SETTLE_CYCLES=1, back-to-back samples, res_ready tied 1:
  - res_valid rises 1 cycle after the last accept;
  - per sample: 11 accept cycles + 1 SETTLE cycle + 1 HOLD cycle → 13-cycle throughput.
- Assert rst mid-SETTLE, then again mid-HOLD:
  - no result emitted; outputs return to reset values the next cycle;
  - sample_cnt=0; feat_ready=1 once rst drops.
- Force sample_cnt to 0xFFFF via 65536 samples (or a reduced CNT_W=2 build with 4 samples): counter wraps to 0.
